// File: rtl/event_recorder_pkg.sv
// Shared types and constants for the event recorder.
// The optional drop counter (EVENT_RECORDER_DROP_CNT_EN) uses DROP_CNT_W and sat_inc.
package event_recorder_pkg;

   localparam int N_EV_DEF   = 8;
   localparam int TS_W_DEF   = 16;
   localparam int DROP_CNT_W = 16;

   typedef struct packed {
      logic [N_EV_DEF-1:0] mask;
      logic [TS_W_DEF-1:0] ts;
   } ev_rec_t;

   // Counter increment that holds at all-ones instead of wrapping
   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/event_recorder_fifo.sv
// Generic synchronous FIFO with extra wrap bit on each pointer for full/empty.
// Head data is read straight from storage and forced to zero while empty.
module event_recorder_fifo #(
   parameter int W     = 24,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int PW = $clog2(DEPTH);

   logic [PW:0]  wrPtr_q, wrPtr_d;
   logic [PW:0]  rdPtr_q, rdPtr_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         pushEn;
   logic         popEn;

   assign empty_o = (wrPtr_q == rdPtr_q);
   assign full_o  = (wrPtr_q[PW] != rdPtr_q[PW]) && (wrPtr_q[PW-1:0] == rdPtr_q[PW-1:0]);

   // A pop frees the slot in the same edge, so a full FIFO still accepts a push
   assign popEn  = pop_i & ~empty_o;
   assign pushEn = push_i & (~full_o | popEn);

   assign head_o = empty_o ? '0 : mem_q[rdPtr_q[PW-1:0]];

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      if (pushEn) wrPtr_d = wrPtr_q + 1'b1;
      if (popEn)  rdPtr_d = rdPtr_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (pushEn) mem_q[wrPtr_q[PW-1:0]] <= data_i;
   end

endmodule

// File: rtl/event_recorder.sv
// Event recorder: sticky/one-cycle event views plus a time-stamped record FIFO.
// Optional EVENT_RECORDER_DROP_CNT_EN adds a saturating drop counter output.
module event_recorder
   import event_recorder_pkg::*;
#(
   parameter int N_EV  = 8,
   parameter int TS_W  = 16,
   parameter int DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_EV-1:0] ev_i,
   input  logic [N_EV-1:0] clr_i,
   output logic [N_EV-1:0] last_o,
   output logic [N_EV-1:0] trig_o,
   output logic            rd_valid_o,
   input  logic            rd_ready_i,
   output logic [N_EV-1:0] rd_mask_o,
   output logic [TS_W-1:0] rd_ts_o,
   output logic            ovf_o
`ifdef EVENT_RECORDER_DROP_CNT_EN
   ,
   output logic [DROP_CNT_W-1:0] drop_cnt_o
`endif
);

   localparam int RW = N_EV + TS_W;

   logic [TS_W-1:0] ts_q, ts_d;
   logic [N_EV-1:0] last_q, last_d;
   logic [N_EV-1:0] trig_q;
   logic            ovf_q, ovf_d;
   logic            push;
   logic            pop;
   logic            drop;
   logic            full;
   logic            empty;
   logic [RW-1:0]   head;

   assign push = |ev_i;
   assign pop  = rd_ready_i & ~empty;
   assign drop = push & full & ~pop;

   event_recorder_fifo #(
      .W     (RW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  ({ev_i, ts_q}),
      .pop_i   (rd_ready_i),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   assign rd_valid_o = ~empty;
   assign rd_mask_o  = head[TS_W +: N_EV];
   assign rd_ts_o    = head[TS_W-1:0];
   assign last_o     = last_q;
   assign trig_o     = trig_q;
   assign ovf_o      = ovf_q;

   // Set has priority over clear so an event in a clearing cycle is never lost
   always_comb begin
      ts_d   = ts_q + 1'b1;
      last_d = (last_q & ~clr_i) | ev_i;
      ovf_d  = ovf_q | drop;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_q   <= '0;
         last_q <= '0;
         trig_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         ts_q   <= ts_d;
         last_q <= last_d;
         trig_q <= ev_i;
         ovf_q  <= ovf_d;
      end
   end

`ifdef EVENT_RECORDER_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] dropCnt_q, dropCnt_d;

   always_comb begin
      dropCnt_d = drop ? sat_inc(dropCnt_q) : dropCnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) dropCnt_q <= '0;
      else     dropCnt_q <= dropCnt_d;
   end

   assign drop_cnt_o = dropCnt_q;
`endif

endmodule

// File: tb/tb_event_recorder.sv
// Self-checking bench for event_recorder: directed scenarios plus randomized traffic
// against a queue-based reference model; a second 4-bit-timestamp instance covers wrap.
module tb_event_recorder;
   import event_recorder_pkg::*;

   localparam int DEPTH = 8;

   typedef struct packed {
      logic [7:0] mask;
      logic [3:0] ts;
   } rec4_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  ev_i = '0;
   logic [7:0]  clr_i = '0;
   logic        rd_ready_i = 1'b0;
   logic [7:0]  ev4 = '0;
   logic [7:0]  clr4 = '0;
   logic        rdy4 = 1'b0;

   logic [7:0]  last_o, trig_o, rd_mask_o;
   logic        rd_valid_o, ovf_o;
   logic [15:0] rd_ts_o;
   logic [7:0]  last4, trig4, mask4;
   logic        valid4, ovf4;
   logic [3:0]  ts4;
`ifdef EVENT_RECORDER_DROP_CNT_EN
   logic [15:0] drop_cnt_o, dropCnt4;
`endif

   ev_rec_t     mq[$];
   rec4_t       q4[$];
   logic [7:0]  mLast, mTrig;
   logic        mOvf;
   int          mDrop;
   logic [15:0] mTs;
   logic [3:0]  mTs4;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   event_recorder #(.N_EV(8), .TS_W(16), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .ev_i(ev_i), .clr_i(clr_i), .last_o(last_o), .trig_o(trig_o),
      .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_mask_o(rd_mask_o),
      .rd_ts_o(rd_ts_o), .ovf_o(ovf_o)
`ifdef EVENT_RECORDER_DROP_CNT_EN
      , .drop_cnt_o(drop_cnt_o)
`endif
   );

   event_recorder #(.N_EV(8), .TS_W(4), .DEPTH(DEPTH)) dut4 (
      .clk(clk), .rst(rst), .ev_i(ev4), .clr_i(clr4), .last_o(last4), .trig_o(trig4),
      .rd_valid_o(valid4), .rd_ready_i(rdy4), .rd_mask_o(mask4),
      .rd_ts_o(ts4), .ovf_o(ovf4)
`ifdef EVENT_RECORDER_DROP_CNT_EN
      , .drop_cnt_o(dropCnt4)
`endif
   );

   task automatic modelReset();
      mq.delete();
      q4.delete();
      mLast = '0;
      mTrig = '0;
      mOvf  = 1'b0;
      mDrop = 0;
      mTs   = '0;
      mTs4  = '0;
   endtask

   // Drives one cycle of inputs, advances the reference model at the edge, returns at negedge
   task automatic applyStimulus(input logic [7:0] ev, input logic [7:0] clr, input logic rdy);
      ev_i       = ev;
      clr_i      = clr;
      rd_ready_i = rdy;
      @(posedge clk);
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (ev != 0) begin
         if (mq.size() < DEPTH) mq.push_back('{mask: ev, ts: mTs});
         else begin
            mOvf = 1'b1;
            if (mDrop < 65535) mDrop++;
         end
      end
      if (rdy4 && q4.size() > 0) void'(q4.pop_front());
      if (ev4 != 0 && q4.size() < DEPTH) q4.push_back('{mask: ev4, ts: mTs4});
      mTrig = ev;
      mLast = (mLast & ~clr) | ev;
      mTs   = mTs + 16'd1;
      mTs4  = mTs4 + 4'd1;
      @(negedge clk);
   endtask

   task automatic doReset();
      ev_i = '0; clr_i = '0; rd_ready_i = 1'b0; ev4 = '0; rdy4 = 1'b0;
      rst = 1'b1;
      modelReset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      vectors++;
      if ({last_o, trig_o, rd_valid_o, rd_mask_o, rd_ts_o, ovf_o} !== 42'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_state: got %h want 0", {last_o, trig_o, rd_valid_o, rd_mask_o, rd_ts_o, ovf_o});
      end
      modelReset();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(8'h00, 8'h00, 1'b0);
         vectors++;
         if ({last_o, trig_o, rd_valid_o} !== 17'd0) begin
            miscompares++;
            $display("[TB] FAIL idle_cycle%0d: last=%h trig=%h valid=%b want all 0", i, last_o, trig_o, rd_valid_o);
         end
      end
   endtask

   task automatic test_two_events();
      applyStimulus(8'h02, 8'h00, 1'b0);
      vectors++;
      if (trig_o !== 8'h02 || last_o !== 8'h02 || rd_valid_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL first_event: trig=%h last=%h valid=%b want 02 02 1", trig_o, last_o, rd_valid_o);
      end
      applyStimulus(8'h04, 8'h00, 1'b0);
      vectors++;
      if (trig_o !== 8'h04 || last_o !== 8'h06) begin
         miscompares++;
         $display("[TB] FAIL second_event: trig=%h last=%h want 04 06", trig_o, last_o);
      end
      vectors++;
      if (rd_mask_o !== 8'h02 || rd_ts_o !== 16'd2) begin
         miscompares++;
         $display("[TB] FAIL head_rec0: mask=%h ts=%0d want 02 2", rd_mask_o, rd_ts_o);
      end
      applyStimulus(8'h00, 8'h00, 1'b1);
      vectors++;
      if (rd_mask_o !== 8'h04 || rd_ts_o !== 16'd3 || trig_o !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL head_rec1: mask=%h ts=%0d trig=%h want 04 3 00", rd_mask_o, rd_ts_o, trig_o);
      end
      applyStimulus(8'h00, 8'h00, 1'b1);
      vectors++;
      if (rd_valid_o !== 1'b0 || rd_mask_o !== 8'h00 || rd_ts_o !== 16'd0) begin
         miscompares++;
         $display("[TB] FAIL drained_empty: valid=%b mask=%h ts=%h want 0 0 0", rd_valid_o, rd_mask_o, rd_ts_o);
      end
   endtask

   task automatic test_clear_and_multi();
      applyStimulus(8'h01, 8'hFF, 1'b0);
      vectors++;
      if (last_o !== 8'h01) begin
         miscompares++;
         $display("[TB] FAIL set_beats_clear: last=%h want 01", last_o);
      end
      applyStimulus(8'h05, 8'h00, 1'b0);
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (rd_valid_o !== 1'b1 || rd_mask_o !== mq[0].mask || rd_ts_o !== mq[0].ts
             || rd_mask_o !== (k == 0 ? 8'h01 : 8'h05)) begin
            miscompares++;
            $display("[TB] FAIL multi_rec%0d: mask=%h ts=%0d want %h %0d", k, rd_mask_o, rd_ts_o, mq[0].mask, mq[0].ts);
         end
         applyStimulus(8'h00, 8'h00, 1'b1);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(8'h01 << (i % 8), 8'h00, 1'b0);
         vectors++;
         if (ovf_o !== (i >= 8)) begin
            miscompares++;
            $display("[TB] FAIL ovf_step%0d: ovf=%b want %b", i, ovf_o, (i >= 8));
         end
      end
`ifdef EVENT_RECORDER_DROP_CNT_EN
      vectors++;
      if (drop_cnt_o !== 16'd2) begin
         miscompares++;
         $display("[TB] FAIL drop_cnt: got %0d want 2", drop_cnt_o);
      end
`endif
      for (int k = 0; k < 8; k++) begin
         vectors++;
         if (rd_valid_o !== 1'b1 || rd_mask_o !== (8'h01 << k) || rd_ts_o !== mq[0].ts) begin
            miscompares++;
            $display("[TB] FAIL ovf_drain%0d: valid=%b mask=%h ts=%0d want 1 %h %0d",
                     k, rd_valid_o, rd_mask_o, rd_ts_o, 8'h01 << k, mq[0].ts);
         end
         applyStimulus(8'h00, 8'h00, 1'b1);
      end
      vectors++;
      if (rd_valid_o !== 1'b0 || ovf_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL ovf_after_drain: valid=%b ovf=%b want 0 1", rd_valid_o, ovf_o);
      end
   endtask

   task automatic test_full_push_pop();
      int count;
      doReset();
      for (int i = 0; i < 8; i++) applyStimulus(8'h01 << i, 8'h00, 1'b0);
      applyStimulus(8'h80, 8'h00, 1'b1);
      vectors++;
      if (ovf_o !== 1'b0 || rd_valid_o !== 1'b1 || rd_mask_o !== 8'h02) begin
         miscompares++;
         $display("[TB] FAIL full_push_pop: ovf=%b valid=%b mask=%h want 0 1 02", ovf_o, rd_valid_o, rd_mask_o);
      end
      count = 0;
      for (int c = 0; c < 20 && rd_valid_o === 1'b1; c++) begin
         count++;
         if (count == 8) begin
            vectors++;
            if (rd_mask_o !== 8'h80 || rd_ts_o !== 16'd8) begin
               miscompares++;
               $display("[TB] FAIL full_last_rec: mask=%h ts=%0d want 80 8", rd_mask_o, rd_ts_o);
            end
         end
         applyStimulus(8'h00, 8'h00, 1'b1);
      end
      vectors++;
      if (count != 8) begin
         miscompares++;
         $display("[TB] FAIL full_count: got %0d want 8", count);
      end
   endtask

   task automatic test_ts_wrap();
      for (int i = 0; i < 20 && mTs4 != 4'd15; i++) applyStimulus(8'h00, 8'h00, 1'b0);
      ev4 = 8'h01;
      applyStimulus(8'h00, 8'h00, 1'b0);
      ev4 = 8'h02;
      applyStimulus(8'h00, 8'h00, 1'b0);
      ev4 = 8'h00;
      vectors++;
      if (mask4 !== 8'h01 || ts4 !== 4'd15 || q4.size() != 2) begin
         miscompares++;
         $display("[TB] FAIL wrap_rec0: mask=%h ts=%0d want 01 15", mask4, ts4);
      end
      rdy4 = 1'b1;
      applyStimulus(8'h00, 8'h00, 1'b0);
      vectors++;
      if (mask4 !== 8'h02 || ts4 !== 4'd0 || ts4 !== q4[0].ts) begin
         miscompares++;
         $display("[TB] FAIL wrap_rec1: mask=%h ts=%0d want 02 0", mask4, ts4);
      end
      applyStimulus(8'h00, 8'h00, 1'b0);
      rdy4 = 1'b0;
   endtask

   task automatic test_reset_midburst();
      ev4 = 8'h08;
      for (int i = 0; i < 3; i++) applyStimulus(8'h11 << (i % 2), 8'h00, 1'b0);
      ev_i = 8'h10;
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({last_o, trig_o, rd_valid_o, rd_mask_o, rd_ts_o, ovf_o,
           last4, trig4, valid4, mask4, ts4, ovf4} !== 72'd0) begin
         miscompares++;
         $display("[TB] FAIL async_reset: main=%h small=%h want 0",
                  {last_o, trig_o, rd_valid_o, rd_mask_o, rd_ts_o, ovf_o}, {last4, trig4, valid4, mask4, ts4, ovf4});
      end
`ifdef EVENT_RECORDER_DROP_CNT_EN
      vectors++;
      if (drop_cnt_o !== 16'd0 || dropCnt4 !== 16'd0) begin
         miscompares++;
         $display("[TB] FAIL async_reset_cnt: %0d %0d want 0", drop_cnt_o, dropCnt4);
      end
`endif
      doReset();
      applyStimulus(8'h20, 8'h00, 1'b0);
      vectors++;
      if (rd_mask_o !== 8'h20 || rd_ts_o !== 16'd0) begin
         miscompares++;
         $display("[TB] FAIL post_reset_rec: mask=%h ts=%0d want 20 0", rd_mask_o, rd_ts_o);
      end
   endtask

   task automatic test_random();
      logic [7:0]  ev, clr;
      logic        rdy;
      logic [41:0] obs, expv;
      doReset();
      for (int i = 0; i < 400; i++) begin
         ev  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         clr = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00;
         rdy = ($urandom_range(0, 2) == 0);
         applyStimulus(ev, clr, rdy);
         obs  = {last_o, trig_o, rd_valid_o, rd_mask_o, rd_ts_o, ovf_o};
         expv = {mLast, mTrig, mq.size() > 0,
                 (mq.size() > 0) ? mq[0].mask : 8'h00,
                 (mq.size() > 0) ? mq[0].ts : 16'h0000, mOvf};
         vectors++;
         if (obs !== expv) begin
            miscompares++;
            $display("[TB] FAIL random_cycle%0d: got %h want %h", i, obs, expv);
         end
`ifdef EVENT_RECORDER_DROP_CNT_EN
         vectors++;
         if (drop_cnt_o !== 16'(mDrop)) begin
            miscompares++;
            $display("[TB] FAIL random_drop%0d: got %0d want %0d", i, drop_cnt_o, mDrop);
         end
`endif
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      modelReset();
      test_reset();
      test_two_events();
      test_clear_and_multi();
      test_overflow();
      test_full_push_pop();
      test_ts_wrap();
      test_reset_midburst();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
